// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 256-word DataMemory between port A
// (core load/store) and port B (debug/loader); at most one access per cycle.
// Latency: grant is combinational; read data, and error pulse, one cycle after acceptance.
// Backpressure: a requester holds req/we/addr/wdata until x_req && x_gnt at an edge.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   {a,b}_req/we/addr/wdata  - request side; {a,b}_gnt combinational accept
//   {a,b}_rvalid/rdata/err   - per-port read response and out-of-range error pulse
//   mem_*                    - DataMemory drive (address, write_data, enables, read_data)
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise A wins ties.
module dmem_arbiter #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic        PORT_A  = 1'b0;
  localparam logic        PORT_B  = 1'b1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic              pend_valid_q, pend_valid_d;
  logic              pend_port_q,  pend_port_d;
  logic              err_valid_q,  err_valid_d;
  logic              err_port_q,   err_port_d;
`ifdef DMEM_ARB_RR_EN
  logic              rr_last_q,    rr_last_d;
`endif

  logic              granted;
  logic              sel_b;
  logic              sel_we;
  logic              sel_in_range;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (a_req && b_req) begin
`ifdef DMEM_ARB_RR_EN
        // On a tie the port that did not win last time goes first.
        if (rr_last_q == PORT_A) b_gnt = 1'b1;
        else                     a_gnt = 1'b1;
`else
        a_gnt = 1'b1;
`endif
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end

    granted      = a_gnt | b_gnt;
    sel_b        = b_gnt;
    sel_we       = sel_b ? b_we    : a_we;
    sel_addr     = sel_b ? b_addr  : a_addr;
    sel_wdata    = sel_b ? b_wdata : a_wdata;
    sel_in_range = sel_addr < DEPTH_W;

    // Address/data follow the winner; an out-of-range access keeps both enables low.
    mem_address      = granted ? sel_addr  : '0;
    mem_write_data   = granted ? sel_wdata : '0;
    mem_write_enable = granted && sel_in_range && sel_we;
    mem_read_enable  = granted && sel_in_range && !sel_we;

    pend_valid_d = mem_read_enable;
    pend_port_d  = sel_b;
    err_valid_d  = granted && !sel_in_range;
    err_port_d   = sel_b;
`ifdef DMEM_ARB_RR_EN
    rr_last_d    = granted ? sel_b : rr_last_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_port_q  <= PORT_A;
      err_valid_q  <= 1'b0;
      err_port_q   <= PORT_A;
`ifdef DMEM_ARB_RR_EN
      rr_last_q    <= PORT_B;
`endif
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_port_q  <= pend_port_d;
      err_valid_q  <= err_valid_d;
      err_port_q   <= err_port_d;
`ifdef DMEM_ARB_RR_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  // Responses are suppressed while rst is high so a read caught by a reset
  // in the following cycle never reports data.
  always_comb begin
    a_rvalid = pend_valid_q && (pend_port_q == PORT_A) && !rst;
    b_rvalid = pend_valid_q && (pend_port_q == PORT_B) && !rst;
    a_rdata  = a_rvalid ? mem_read_data : '0;
    b_rdata  = b_rvalid ? mem_read_data : '0;
    a_err    = err_valid_q && (err_port_q == PORT_A) && !rst;
    b_err    = err_valid_q && (err_port_q == PORT_B) && !rst;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gap;
  } cmd_t;

  typedef struct {
    int          due;
    bit          is_err;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_write_enable, mem_read_enable;
  logic [31:0] mem_read_data = '0;

  // driven request state, index 0 = port A, 1 = port B
  logic        d_req  [2];
  logic        d_we   [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wd   [2];
  bit          acc    [2];
  bit          acc_last [2];
  bit          have   [2];
  cmd_t        cur    [2];
  cmd_t        cq_a[$], cq_b[$];

  resp_t       qa[$], qb[$];
  logic [31:0] ref_mem [256] = '{default: '0};
  logic [31:0] mem     [256] = '{default: '0};
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
`ifdef DMEM_ARB_RR_EN
  bit          m_rr_last_b = 1'b1;
`endif

  dmem_arbiter #(.DEPTH(256), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_req(d_req[0]), .a_we(d_we[0]), .a_addr(d_addr[0]), .a_wdata(d_wd[0]),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(d_req[1]), .b_we(d_we[1]), .b_addr(d_addr[1]), .b_wdata(d_wd[1]),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DataMemory stand-in: synchronous write and registered read
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_address[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model + scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit          eg_a, eg_b, g, s_b, s_we, in_r;
    logic [31:0] s_addr, s_wd;
    bit          ev, ee;
    logic [31:0] ed;
    resp_t       r;

    eg_a = 0;
    eg_b = 0;
    if (!rst) begin
      if (d_req[0] && d_req[1]) begin
`ifdef DMEM_ARB_RR_EN
        eg_a = m_rr_last_b;
        eg_b = !m_rr_last_b;
`else
        eg_a = 1;
`endif
      end else begin
        eg_a = d_req[0];
        eg_b = d_req[1];
      end
    end
    chk("grant", 64'({a_gnt, b_gnt}), 64'({eg_a, eg_b}));

    g      = eg_a || eg_b;
    s_b    = eg_b;
    s_we   = s_b ? d_we[1]   : d_we[0];
    s_addr = s_b ? d_addr[1] : d_addr[0];
    s_wd   = s_b ? d_wd[1]   : d_wd[0];
    in_r   = s_addr < 32'd256;
    chk("mem_enables", 64'({mem_write_enable, mem_read_enable}),
        64'({g && in_r && s_we, g && in_r && !s_we}));
    if (!g)
      chk("mem_idle_bus", {mem_address, mem_write_data}, 64'd0);
    else if (in_r)
      chk("mem_bus", {mem_address, mem_write_data}, {s_addr, s_wd});

    ev = 0; ee = 0; ed = '0;
    if (qa.size() > 0 && qa[0].due <= cyc) begin
      r = qa.pop_front();
      if (!rst) begin ev = !r.is_err; ee = r.is_err; ed = r.is_err ? 32'd0 : r.data; end
    end
    chk("resp_a", 64'({a_rvalid, a_err, a_rdata}), 64'({ev, ee, ed}));

    ev = 0; ee = 0; ed = '0;
    if (qb.size() > 0 && qb[0].due <= cyc) begin
      r = qb.pop_front();
      if (!rst) begin ev = !r.is_err; ee = r.is_err; ed = r.is_err ? 32'd0 : r.data; end
    end
    chk("resp_b", 64'({b_rvalid, b_err, b_rdata}), 64'({ev, ee, ed}));

    if (rst) begin
`ifdef DMEM_ARB_RR_EN
      m_rr_last_b = 1'b1;
`endif
    end else if (g) begin
`ifdef DMEM_ARB_RR_EN
      m_rr_last_b = s_b;
`endif
      r.due = cyc + 1;
      r.is_err = !in_r;
      r.data = '0;
      if (in_r && s_we) begin
        ref_mem[s_addr[7:0]] = s_wd;
      end else begin
        if (in_r) r.data = ref_mem[s_addr[7:0]];
        if (s_b) qb.push_back(r);
        else     qa.push_back(r);
      end
    end

    acc[0] = d_req[0] && a_gnt;
    acc[1] = d_req[1] && b_gnt;
    cyc++;
  end

  function automatic bit idle();
    return cq_a.size() == 0 && cq_b.size() == 0 && !have[0] && !have[1]
           && !d_req[0] && !d_req[1];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      acc_last[p] = d_req[p] && acc[p];
      if (!d_req[p] || acc[p]) begin
        d_req[p] = 1'b0;
        if (!have[p]) begin
          if (p == 0 && cq_a.size() > 0) begin cur[p] = cq_a.pop_front(); have[p] = 1; end
          if (p == 1 && cq_b.size() > 0) begin cur[p] = cq_b.pop_front(); have[p] = 1; end
        end
        if (have[p]) begin
          if (cur[p].gap > 0) begin
            cur[p].gap--;
          end else begin
            d_req[p]  = 1'b1;
            d_we[p]   = cur[p].we;
            d_addr[p] = cur[p].addr;
            d_wd[p]   = cur[p].wd;
            have[p]   = 0;
          end
        end
      end
    end
  endtask

  task automatic push(input int p, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input int gap);
    cmd_t c;
    c.we = we; c.addr = addr; c.wd = wd; c.gap = gap;
    if (p == 0) cq_a.push_back(c);
    else        cq_b.push_back(c);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !idle(); i++) step();
    chk("drain_timeout", 64'(idle()), 64'd1);
    step();
    step();
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int   k;
    c.we = 1'($urandom_range(0, 1));
    k = 32'($urandom_range(0, 9));
    if (k < 7)       c.addr = 32'($urandom_range(0, 15));
    else if (k < 9)  c.addr = 32'($urandom_range(0, 255));
    else if (k == 9 && $urandom_range(0, 1) == 0) c.addr = 32'hFFFF_FFF0;
    else             c.addr = 32'($urandom_range(256, 1000));
    c.wd  = $urandom;
    c.gap = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 2)) : 0;
    return c;
  endfunction

  initial begin
    for (int p = 0; p < 2; p++) begin
      have[p] = 0; acc[p] = 0; acc_last[p] = 0;
    end
    // both ports request reads through reset; A must win the first cycle after it
    rst = 1'b1;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'd1; d_wd[0] = '0;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'd2; d_wd[1] = '0;
    step();
    step();
    rst = 1'b0;
    drain();

    // write then read back on A
    push(0, 1, 32'd5, 32'hDEAD_BEEF, 0);
    push(0, 0, 32'd5, 32'd0, 0);
    drain();

    // sustained contention: A reads addr 1, B reads addr 2
    for (int i = 0; i < 6; i++) begin
      push(0, 0, 32'd1, 32'd0, 0);
      push(1, 0, 32'd2, 32'd0, 0);
    end
    drain();

    // out of range write must be dropped and flagged
    push(1, 1, 32'd44,  32'hCAFE_0044, 0);
    push(1, 1, 32'd300, 32'hBAD0_BAD0, 0);
    push(1, 0, 32'd44,  32'd0, 0);
    push(1, 0, 32'd300, 32'd0, 0);
    drain();

    // reset in the cycle after an accepted read
    push(0, 0, 32'd5, 32'd0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_last[0]) break;
    end
    chk("midread_accept", 64'(acc_last[0]), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drain();

    // A read, B write, A read of the same address in consecutive grants
    push(0, 0, 32'd3, 32'd0, 0);
    push(1, 1, 32'd3, 32'h0000_1234, 1);
    push(0, 0, 32'd3, 32'd0, 1);
    drain();

    // random mixed traffic
    for (int i = 0; i < 500; i++) begin
      if (cq_a.size() < 2 && $urandom_range(0, 1) == 1) cq_a.push_back(rand_cmd());
      if (cq_b.size() < 2 && $urandom_range(0, 1) == 1) cq_b.push_back(rand_cmd());
      step();
    end
    drain();

    chk("leftover_a", 64'(qa.size()), 64'd0);
    chk("leftover_b", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
